usbdev_aon_resume_tx: RTL and testbench
=======================================

// Module: usbdev_aon_resume_tx
// PURPOSE
// - Always-on USB remote-wakeup transmitter: the device-initiated counterpart to the AON wake detector.
// - On a firmware remote-wake request during suspend, it waits for bus idle, then drives resume signalling (K) on D+/D-.
// - Sits in the AON domain beside the wake detector; its pad outputs are muxed onto the USB PHY while the AON block owns the link.
// PARAMETERS
// - IdleCycles    400  clk_aon_i cycles of continuous J required before driving K (2 ms at 200 kHz); >=1
// - ResumeCycles  400  clk_aon_i cycles K is driven (USB spec 1..15 ms); >=1
// - CntW          16   counter width; must hold max(IdleCycles, ResumeCycles)
// PORTS
// - clk_aon_i                in   1  AON clock (~200 kHz)
// - rst_aon_i                in   1  reset, synchronous, active-high
// - usb_dp_i                 in   1  D+ pin level, asynchronous; 2-flop synchronized internally
// - usb_dn_i                 in   1  D- pin level, asynchronous; 2-flop synchronized internally
// - usb_sense_i              in   1  VBUS sense, already AON-synchronized
// - pinflip_aon_i            in   1  D+/D- swapped at pins; AON-synchronized
// - wake_detect_active_aon_i in   1  AON block owns the link (suspended)
// - remote_wake_req_aon_i    in   1  level request from IP, AON-synchronized
// - usb_oe_o                 out  1  pad output enable
// - usb_dp_o                 out  1  D+ drive value
// - usb_dn_o                 out  1  D- drive value
// - resume_active_o          out  1  high in WAIT_IDLE or DRIVE_K
// - resume_done_o            out  1  1-cycle pulse: K completed
// - resume_abort_o           out  1  1-cycle pulse: attempt abandoned
// BEHAVIOUR
// - Reset: state IDLE, counter 0, armed=1; all outputs 0.
// - J = (dp,dn)=(1,0); K = (0,1); both swapped when pinflip_aon_i=1. Line check uses synchronized pins (2-cycle latency).
// - IDLE: oe=0, dp_o=dn_o=0. Go to WAIT_IDLE (cnt<=0) when req & armed & wake_detect_active & sense.
// - WAIT_IDLE, priority order:
//   1. req=0 -> IDLE, no pulse.
//   2. sense=0 or wake_detect_active=0 -> abort pulse, IDLE.
//   3. synced line != J (host resume/reset) -> abort pulse, IDLE.
//   4. cnt==IdleCycles-1 -> DRIVE_K, cnt<=0.
//   5. otherwise cnt++.
// - DRIVE_K: oe=1, dp_o/dn_o = K. Line inputs ignored (own drive). req and wake_detect_active changes are ignored, so the minimum resume duration is always met.
//   - sense=0 -> oe=0 next cycle, abort pulse, IDLE.
//   - cnt==ResumeCycles-1 -> IDLE with oe=0 and done pulse on the same edge (K lasts exactly ResumeCycles cycles).
// - Re-arm: done or abort clears armed; armed sets when req=0. A held req never retriggers.
// - Simultaneous events follow the priority order above; in DRIVE_K, sense loss beats completion (abort, not done).
// - resume_active_o = (state!=IDLE); done and abort are mutually exclusive and never repeat without re-arm.
// - Reset asserted in any state -> IDLE next edge; oe drops immediately on that edge.
// - Counter saturates; no wrap is possible while CntW satisfies the parameter rule.
// TESTING (IdleCycles=4, ResumeCycles=8)
// - Suspended, sense=1, line J, req 0->1 -> WAIT_IDLE 4 cycles, then oe=1,(dp,dn)=(0,1) for 8 cycles, done pulse, oe=0.
// - Same with pinflip=1 -> K driven as (dp,dn)=(1,0); J detection inverted accordingly.
// - Line goes SE0 in cycle 2 of WAIT_IDLE -> abort pulse (after 2-cycle sync latency), oe never asserted.
// - sense drops in cycle 5 of DRIVE_K -> oe=0 next cycle, abort=1, done never pulses.
// - req held high after done -> no second K; req 0 then 1 -> new full sequence.
// - req dropped in WAIT_IDLE -> IDLE with no pulses; rst_aon_i mid DRIVE_K -> all outputs 0 next cycle.

Source files
------------

// File: rtl/usbdev_aon_resume_tx.sv
// Always-on remote-wakeup transmitter: once the bus has been idle (J) long enough, drives resume K on D+/D-.
// Single registered FSM; pad outputs and status pulses change only on clock edges.
module usbdev_aon_resume_tx #(
  parameter int unsigned IdleCycles   = 400,
  parameter int unsigned ResumeCycles = 400,
  parameter int unsigned CntW         = 16
) (
  input  logic clk_aon_i,
  input  logic rst_aon_i,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  input  logic usb_sense_i,
  input  logic pinflip_aon_i,
  input  logic wake_detect_active_aon_i,
  input  logic remote_wake_req_aon_i,
  output logic usb_oe_o,
  output logic usb_dp_o,
  output logic usb_dn_o,
  output logic resume_active_o,
  output logic resume_done_o,
  output logic resume_abort_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IDLE,
    DRIVE_K
  } state_e;

  localparam logic [CntW-1:0] IdleLast   = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] ResumeLast = CntW'(ResumeCycles - 1);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic            armed;
  logic [1:0]      dp_sync;
  logic [1:0]      dn_sync;
  logic            line_j;
  logic            k_dp;

  // Pins are asynchronous to the AON clock; no reset needed on the synchronizer.
  always_ff @(posedge clk_aon_i) begin
    dp_sync <= {dp_sync[0], usb_dp_i};
    dn_sync <= {dn_sync[0], usb_dn_i};
  end

  assign line_j  = pinflip_aon_i ? (!dp_sync[1] && dn_sync[1]) : (dp_sync[1] && !dn_sync[1]);
  assign k_dp    = pinflip_aon_i;
  assign cnt_inc = (cnt == CntMax) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_aon_i) begin
    if (rst_aon_i) begin
      state           <= IDLE;
      cnt             <= '0;
      armed           <= 1'b1;
      usb_oe_o        <= 1'b0;
      usb_dp_o        <= 1'b0;
      usb_dn_o        <= 1'b0;
      resume_active_o <= 1'b0;
      resume_done_o   <= 1'b0;
      resume_abort_o  <= 1'b0;
    end else begin
      resume_done_o  <= 1'b0;
      resume_abort_o <= 1'b0;
      if (!remote_wake_req_aon_i) armed <= 1'b1;
      case (state)
        IDLE: begin
          usb_oe_o <= 1'b0;
          usb_dp_o <= 1'b0;
          usb_dn_o <= 1'b0;
          if (remote_wake_req_aon_i && armed && wake_detect_active_aon_i && usb_sense_i) begin
            state           <= WAIT_IDLE;
            cnt             <= '0;
            resume_active_o <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!remote_wake_req_aon_i) begin
            state           <= IDLE;
            resume_active_o <= 1'b0;
          end else if (!usb_sense_i || !wake_detect_active_aon_i || !line_j) begin
            state           <= IDLE;
            resume_active_o <= 1'b0;
            resume_abort_o  <= 1'b1;
            armed           <= 1'b0;
          end else if (cnt == IdleLast) begin
            state    <= DRIVE_K;
            cnt      <= '0;
            usb_oe_o <= 1'b1;
            usb_dp_o <= k_dp;
            usb_dn_o <= !k_dp;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DRIVE_K: begin
          // Only VBUS loss may cut K short; everything else waits for the full duration.
          if (!usb_sense_i || cnt == ResumeLast) begin
            state           <= IDLE;
            resume_active_o <= 1'b0;
            usb_oe_o        <= 1'b0;
            usb_dp_o        <= 1'b0;
            usb_dn_o        <= 1'b0;
            armed           <= 1'b0;
            resume_abort_o  <= !usb_sense_i;
            resume_done_o   <= usb_sense_i;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state           <= IDLE;
          resume_active_o <= 1'b0;
          usb_oe_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbdev_aon_resume_tx.sv
// Directed bench for usbdev_aon_resume_tx with IdleCycles=4, ResumeCycles=8.
module tb_usbdev_aon_resume_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dp = 1'b1, dn = 1'b0, sense = 1'b1, pinflip = 1'b0, wda = 1'b1, req = 1'b0;
  logic oe, dp_o, dn_o, active, done, abort;
  int   checks = 0;
  int   errors = 0;

  usbdev_aon_resume_tx #(.IdleCycles(4), .ResumeCycles(8), .CntW(16)) dut (
    .clk_aon_i                (clk),
    .rst_aon_i                (rst),
    .usb_dp_i                 (dp),
    .usb_dn_i                 (dn),
    .usb_sense_i              (sense),
    .pinflip_aon_i            (pinflip),
    .wake_detect_active_aon_i (wda),
    .remote_wake_req_aon_i    (req),
    .usb_oe_o                 (oe),
    .usb_dp_o                 (dp_o),
    .usb_dn_o                 (dn_o),
    .resume_active_o          (active),
    .resume_done_o            (done),
    .resume_abort_o           (abort)
  );

  always #5 clk = ~clk;

  // Outputs packed as {oe, dp, dn, active, done, abort}.
  localparam logic [5:0] OFF   = 6'b000000;
  localparam logic [5:0] WAIT  = 6'b000100;
  localparam logic [5:0] KNORM = 6'b101100;
  localparam logic [5:0] KFLIP = 6'b110100;
  localparam logic [5:0] DONE  = 6'b000010;
  localparam logic [5:0] ABRT  = 6'b000001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {oe, dp_o, dn_o, active, done, abort};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input string tag, input int n, input logic [5:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, exp);
    end
  endtask

  task automatic full_seq(input string tag, input logic [5:0] kexp);
    req = 1'b1;
    expect_run({tag, "_wait"}, 4, WAIT);
    expect_run({tag, "_k"}, 8, kexp);
    expect_run({tag, "_done"}, 1, DONE);
    expect_run({tag, "_off"}, 1, OFF);
  endtask

  task automatic rearm();
    req = 1'b0;
    tick();
  endtask

  initial begin
    tick(); tick(); tick();
    check("reset", OFF);
    rst = 1'b0;
    expect_run("idle_after_reset", 2, OFF);

    full_seq("basic", KNORM);
    expect_run("held_req_no_retrigger", 6, OFF);
    rearm();
    check("rearm_idle", OFF);
    full_seq("second", KNORM);

    // Pin-swapped: J is (0,1), K driven as (1,0).
    rearm();
    pinflip = 1'b1; dp = 1'b0; dn = 1'b1;
    tick(); tick(); tick();
    full_seq("flip", KFLIP);

    // SE0 appears during WAIT_IDLE cycle 2; seen two edges later, beating the K transition.
    rearm();
    pinflip = 1'b0; dp = 1'b1; dn = 1'b0;
    tick(); tick(); tick();
    req = 1'b1;
    expect_run("se0_wait", 2, WAIT);
    dp = 1'b0; dn = 1'b0;
    expect_run("se0_sync_latency", 2, WAIT);
    expect_run("se0_abort", 1, ABRT);
    expect_run("se0_after", 3, OFF);
    dp = 1'b1; dn = 1'b0;
    tick(); tick(); tick();

    // VBUS lost in the fifth K cycle.
    rearm();
    req = 1'b1;
    expect_run("sense_wait", 4, WAIT);
    expect_run("sense_k", 5, KNORM);
    sense = 1'b0;
    expect_run("sense_abort", 1, ABRT);
    expect_run("sense_no_done", 4, OFF);
    sense = 1'b1;

    // Wake-detect ownership lost in WAIT_IDLE.
    rearm();
    req = 1'b1;
    expect_run("wda_wait", 2, WAIT);
    wda = 1'b0;
    expect_run("wda_abort", 1, ABRT);
    expect_run("wda_after", 2, OFF);
    wda = 1'b1;

    // Suspend ownership change during K is ignored.
    rearm();
    req = 1'b1;
    expect_run("kwda_wait", 4, WAIT);
    expect_run("kwda_k", 2, KNORM);
    wda = 1'b0; req = 1'b0;
    expect_run("kwda_k_ignored", 6, KNORM);
    expect_run("kwda_done", 1, DONE);
    wda = 1'b1;
    expect_run("kwda_off", 1, OFF);

    // Request withdrawn during WAIT_IDLE: silent return.
    rearm();
    req = 1'b1;
    expect_run("drop_wait", 2, WAIT);
    req = 1'b0;
    expect_run("drop_silent", 3, OFF);

    // Reset mid-K: outputs drop on the reset edge.
    req = 1'b1;
    expect_run("rst_wait", 4, WAIT);
    expect_run("rst_k", 3, KNORM);
    rst = 1'b1;
    expect_run("rst_mid_k", 1, OFF);
    rst = 1'b0;
    expect_run("rst_rearmed_wait", 1, WAIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
